text_term_ctrl: RTL and testbench

Sequences all writes into the character video RAM that the VGA text renderer reads. It turns keyboard events into character-RAM writes and cursor moves:
- printable key
- backspace
- enter
- scroll-up
- screen clear

It also drives the cursor position and blink phase to the renderer. It sits between the keyboard decoder and the character RAM's second (write/read) port; the renderer keeps its own read port.

---
 rtl/text_term_pkg.sv | 27 ++
 rtl/text_term_ctrl_blink.sv | 45 ++++
 rtl/text_term_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_text_term_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_term_pkg.sv
// Shared constants, state encoding and address helper for the text terminal controller.
package text_term_pkg;

    localparam int unsigned COLS   = 70;
    localparam int unsigned ROWS   = 30;
    localparam int unsigned ADDR_W = 12;

    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [2:0] {
        StClrAll,
        StIdle,
        StWrite,
        StScroll,
        StClrRow
    } state_e;

    // Linear cell address row*COLS+col, computed at full address width.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
        logic [ADDR_W-1:0] xa;
        logic [ADDR_W-1:0] ya;
        xa = ADDR_W'(x);
        ya = ADDR_W'(y);
        return ya * ADDR_W'(COLS) + xa;
    endfunction

endpackage

// File: rtl/text_term_ctrl_blink.sv
// Cursor blink generator: free-running half-period counter with a restart input.
module blink_gen #(
    parameter int unsigned BLINK_CYC = 25000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic restart_i,
    output logic blink_on_o
);

    localparam int unsigned CNT_W    = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;

    // Next counter/phase: restart shows the cursor immediately, else toggle on wrap.
    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (restart_i) begin
            cnt_d   = '0;
            blink_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign blink_on_o = blink_q;

endmodule

// File: rtl/text_term_ctrl.sv
// Text terminal controller: turns key events into character-RAM writes, cursor moves
// and full-screen scrolling, and drives cursor position/blink to the renderer.
module text_term_ctrl
    import text_term_pkg::*;
#(
    parameter int unsigned BLINK_CYC = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_press,
    input  logic [7:0]        ascii,
    input  logic              if_back,
    input  logic              if_enter,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              blink_on,
    output logic              busy
);

    localparam logic [6:0]        X_LAST        = 7'(COLS - 1);
    localparam logic [4:0]        Y_LAST        = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CELLS_LAST    = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] COPY_LAST     = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST      = ADDR_W'(COLS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [6:0]        cx_q, cx_d;
    logic [4:0]        cy_q, cy_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              copy_q, copy_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              scroll_pend_q, scroll_pend_d;
    logic              accept;
    logic              printable;

    assign printable = (ascii >= 8'h20) && (ascii <= 8'h7E);

    // Next-state, cursor and registered write-port decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        copy_d        = 1'b0;
        rd_addr_d     = rd_addr_q;
        scroll_pend_d = scroll_pend_q;
        accept        = 1'b0;
        case (state_q)
            // Reset holds wr_en low for the first cycle, so the final clear
            // write is presented in the first IDLE cycle.
            StClrAll: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = SPACE;
                if (cnt_q == CELLS_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            StIdle: begin
                if (if_enter) begin
                    accept = 1'b1;
                    cx_d   = '0;
                    if (cy_q != Y_LAST) begin
                        cy_d = cy_q + 5'd1;
                    end else begin
                        state_d   = StScroll;
                        cnt_d     = '0;
                        rd_addr_d = COLS_A;
                    end
                end else if (if_back) begin
                    if (cx_q != '0 || cy_q != '0) begin
                        accept    = 1'b1;
                        state_d   = StWrite;
                        wr_en_d   = 1'b1;
                        wr_data_d = SPACE;
                        if (cx_q != '0) begin
                            cx_d = cx_q - 7'd1;
                        end else begin
                            cx_d = X_LAST;
                            cy_d = cy_q - 5'd1;
                        end
                        wr_addr_d = cell_addr(cx_d, cy_d);
                    end
                end else if (if_press && printable) begin
                    accept    = 1'b1;
                    state_d   = StWrite;
                    wr_en_d   = 1'b1;
                    wr_addr_d = cell_addr(cx_q, cy_q);
                    wr_data_d = ascii;
                    if (cx_q != X_LAST) begin
                        cx_d = cx_q + 7'd1;
                    end else begin
                        cx_d = '0;
                        if (cy_q != Y_LAST) cy_d = cy_q + 5'd1;
                        else                scroll_pend_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                if (scroll_pend_q) begin
                    state_d       = StScroll;
                    cnt_d         = '0;
                    rd_addr_d     = COLS_A;
                    scroll_pend_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            // cnt_q is the scroll cycle index: read row+1 now, write the word read
            // last cycle (data taken straight from rd_data via copy_q).
            StScroll: begin
                if (cnt_q == LAST_ROW_BASE) begin
                    state_d   = StClrRow;
                    cnt_d     = '0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = LAST_ROW_BASE;
                    wr_data_d = SPACE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    copy_d    = 1'b1;
                    cnt_d     = cnt_q + ADDR_W'(1);
                    if (cnt_q != COPY_LAST) rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            StClrRow: begin
                if (cnt_q == ROW_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    wr_data_d = SPACE;
                    cnt_d     = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = StClrAll;
        endcase
    end

    // State, cursor and write/read port registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StClrAll;
            cnt_q         <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= SPACE;
            copy_q        <= 1'b0;
            rd_addr_q     <= '0;
            scroll_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            copy_q        <= copy_d;
            rd_addr_q     <= rd_addr_d;
            scroll_pend_q <= scroll_pend_d;
        end
    end

    blink_gen #(
        .BLINK_CYC(BLINK_CYC)
    ) u_blink (
        .clk_i     (clk),
        .reset_i   (reset),
        .restart_i (accept),
        .blink_on_o(blink_on)
    );

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = copy_q ? rd_data : wr_data_q;
    assign rd_addr  = rd_addr_q;
    assign cursor_x = cx_q;
    assign cursor_y = cy_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_text_term_ctrl.sv
// Directed bench for text_term_ctrl with a behavioural 1-cycle-latency character RAM.
module tb_text_term_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_press = 1'b0;
    logic [7:0]  ascii = 8'h00;
    logic        if_back = 1'b0;
    logic        if_enter = 1'b0;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        blink_on;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int base;
    int busy_cnt;
    logic [11:0] last_wr_addr = '0;
    logic [7:0]  last_wr_data = '0;
    logic [7:0]  ram [0:4095];
    logic [7:0]  exp_ram [0:2099];

    text_term_ctrl #(
        .BLINK_CYC(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .if_press(if_press),
        .ascii   (ascii),
        .if_back (if_back),
        .if_enter(if_enter),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
        .blink_on(blink_on),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency; also logs writes.
    always @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= wr_addr;
            last_wr_data <= wr_data;
        end
        rd_data <= ram[rd_addr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cursor_is(input string tag, input int x, input int y);
        check({tag, "_x"}, 32'(cursor_x), 32'(x));
        check({tag, "_y"}, 32'(cursor_y), 32'(y));
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic pulse(input logic e, input logic b, input logic p, input logic [7:0] a);
        if_enter = e;
        if_back  = b;
        if_press = p;
        ascii    = a;
        @(negedge clk);
        if_enter = 1'b0;
        if_back  = 1'b0;
        if_press = 1'b0;
    endtask

    task automatic type_key(input logic [7:0] a, input int x, input int y);
        pulse(1'b0, 1'b0, 1'b1, a);
        exp_ram[y * 70 + x] = a;
        @(negedge clk);
    endtask

    task automatic ram_check(input string tag);
        int bad = 0;
        for (int i = 0; i < 2100; i++) if (ram[i] !== exp_ram[i]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'h20);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_blink", 32'(blink_on), 32'd0);
        cursor_is("rst_cursor", 0, 0);

        // Power-up clear.
        reset = 1'b0;
        busy_cnt = 0;
        while (busy === 1'b1 && busy_cnt < 3000) begin
            busy_cnt++;
            @(negedge clk);
        end
        check("clr_all_busy_cycles", 32'(busy_cnt), 32'd2100);
        check("clr_all_last_addr", 32'(wr_addr), 32'd2099);
        @(negedge clk);
        check("clr_all_writes", 32'(wr_cnt), 32'd2100);
        for (int i = 0; i < 2100; i++) exp_ram[i] = 8'h20;
        ram_check("clr_all_ram");
        cursor_is("clr_all_cursor", 0, 0);
        check("clr_all_idle", 32'(busy), 32'd0);

        // Printable key at the origin.
        pulse(1'b0, 1'b0, 1'b1, 8'h41);
        check("key_a_wr_en", 32'(wr_en), 32'd1);
        check("key_a_addr", 32'(wr_addr), 32'd0);
        check("key_a_data", 32'(wr_data), 32'h41);
        check("key_a_busy", 32'(busy), 32'd1);
        cursor_is("key_a_cursor", 1, 0);
        exp_ram[0] = 8'h41;
        @(negedge clk);
        check("key_a_done", 32'(busy), 32'd0);
        check("key_a_one_write", 32'(wr_en), 32'd0);

        // Non-printable key is ignored.
        base = wr_cnt;
        pulse(1'b0, 1'b0, 1'b1, 8'h07);
        check("bel_no_wr_en", 32'(wr_en), 32'd0);
        check("bel_not_busy", 32'(busy), 32'd0);
        cursor_is("bel_cursor", 1, 0);
        repeat (2) @(negedge clk);
        check("bel_no_write", 32'(wr_cnt - base), 32'd0);

        // Reach (5,2), then coincident enter+back+press.
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) type_key(8'h61 + 8'(i), i, 2);
        cursor_is("pre_coinc_cursor", 5, 2);
        base = wr_cnt;
        pulse(1'b1, 1'b1, 1'b1, 8'h42);
        cursor_is("coinc_cursor", 0, 3);
        check("coinc_no_wr_en", 32'(wr_en), 32'd0);
        check("coinc_not_busy", 32'(busy), 32'd0);
        check("blink_on_accept", 32'(blink_on), 32'd1);
        repeat (3) @(negedge clk);
        check("blink_hold", 32'(blink_on), 32'd1);
        @(negedge clk);
        check("blink_toggle", 32'(blink_on), 32'd0);
        @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        check("blink_restart", 32'(blink_on), 32'd1);
        check("coinc_no_write", 32'(wr_cnt - base), 32'd0);
        repeat (3) @(negedge clk);
        check("blink_restart_hold", 32'(blink_on), 32'd1);
        @(negedge clk);
        check("blink_restart_wrap", 32'(blink_on), 32'd0);

        // Fill row 5 and wrap to row 6, then backspace across the row boundary.
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 70; i++) type_key(8'h21 + 8'(i), i, 5);
        check("row5_last_addr", 32'(last_wr_addr), 32'd419);
        check("row5_last_data", 32'(last_wr_data), 32'h66);
        cursor_is("row5_wrap_cursor", 0, 6);
        pulse(1'b0, 1'b1, 1'b0, 8'h00);
        cursor_is("bs_cursor", 69, 5);
        check("bs_wr_en", 32'(wr_en), 32'd1);
        check("bs_addr", 32'(wr_addr), 32'd419);
        check("bs_data", 32'(wr_data), 32'h20);
        exp_ram[419] = 8'h20;
        @(negedge clk);
        ram_check("typed_ram");

        // Move to (3,29) and scroll with enter.
        repeat (24) pulse(1'b1, 1'b0, 1'b0, 8'h00);
        cursor_is("bottom_cursor", 0, 29);
        for (int i = 0; i < 3; i++) type_key(8'h58 + 8'(i), i, 29);
        base = wr_cnt;
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        cursor_is("scroll_cursor", 0, 29);
        busy_cnt = 0;
        while (busy === 1'b1 && busy_cnt < 3000) begin
            busy_cnt++;
            if (busy_cnt == 1) begin
                check("scroll_rd_first", 32'(rd_addr), 32'd70);
                check("scroll_first_no_wr", 32'(wr_en), 32'd0);
            end
            if (busy_cnt == 2) begin
                check("scroll_copy0_en", 32'(wr_en), 32'd1);
                check("scroll_copy0_addr", 32'(wr_addr), 32'd0);
            end
            if (busy_cnt == 282) begin
                check("scroll_copy280_addr", 32'(wr_addr), 32'd280);
                check("scroll_copy280_data", 32'(wr_data), 32'h21);
            end
            if (busy_cnt == 2031) check("scroll_last_copy", 32'(wr_addr), 32'd2029);
            if (busy_cnt == 2032) begin
                check("clr_row_first_addr", 32'(wr_addr), 32'd2030);
                check("clr_row_first_data", 32'(wr_data), 32'h20);
            end
            if (busy_cnt == 500) begin
                if_press = 1'b1;
                ascii    = 8'h5A;
            end
            if (busy_cnt == 501) if_press = 1'b0;
            if (busy_cnt == 2040) if_back = 1'b1;
            if (busy_cnt == 2041) if_back = 1'b0;
            if (busy_cnt == 2101) begin
                if_press = 1'b1;
                ascii    = 8'h51;
            end
            @(negedge clk);
        end
        if_press = 1'b0;
        if_back  = 1'b0;
        check("scroll_busy_cycles", 32'(busy_cnt), 32'd2101);
        @(negedge clk);
        check("scroll_write_count", 32'(wr_cnt - base), 32'd2100);
        check("scroll_quiet_after", 32'(wr_en), 32'd0);
        for (int a = 0; a < 2030; a++) exp_ram[a] = exp_ram[a + 70];
        for (int a = 2030; a < 2100; a++) exp_ram[a] = 8'h20;
        ram_check("scroll_ram");
        cursor_is("post_scroll_cursor", 0, 29);

        // Reset in the middle of a scroll.
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (100) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'h20);
        check("midrst_rd_addr", 32'(rd_addr), 32'd0);
        check("midrst_busy", 32'(busy), 32'd1);
        check("midrst_blink", 32'(blink_on), 32'd0);
        cursor_is("midrst_cursor", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        base = wr_cnt;
        @(negedge clk);
        check("restart_wr_en", 32'(wr_en), 32'd1);
        check("restart_addr", 32'(wr_addr), 32'd0);
        check("restart_data", 32'(wr_data), 32'h20);
        busy_cnt = 0;
        while (busy === 1'b1 && busy_cnt < 3000) begin
            busy_cnt++;
            @(negedge clk);
        end
        check("restart_busy_cycles", 32'(busy_cnt), 32'd2099);
        @(negedge clk);
        check("restart_writes", 32'(wr_cnt - base), 32'd2100);
        for (int i = 0; i < 2100; i++) exp_ram[i] = 8'h20;
        ram_check("restart_ram");
        cursor_is("restart_cursor", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
